// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, address-region decode constants
// and response status codes.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_SETUP  = 2'b01,
        APB_ACCESS = 2'b10
    } apb_state_e;

    // Region field of the address that selects the slave
    localparam int REGION_HI = 31;
    localparam int REGION_LO = 30;

    localparam logic [1:0] REGION_S0 = 2'b00;
    localparam logic [1:0] REGION_S1 = 2'b01;
    localparam logic [1:0] REGION_S2 = 2'b10;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_S0   = 3'b001;
    localparam logic [2:0] SEL_S1   = 3'b010;
    localparam logic [2:0] SEL_S2   = 3'b100;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/apb_addr_decode.sv
// Maps an address region field onto a one-hot APB select plus a mapped flag.
// Region 2'b11 has no slave behind it.
module apb_addr_decode
    import apb_pkg::*;
(
    input  logic [1:0] i_region,
    output logic [2:0] o_sel,
    output logic       o_mapped
);

    always_comb begin
        o_sel    = SEL_NONE;
        o_mapped = 1'b0;
        case (i_region)
            REGION_S0: begin
                o_sel    = SEL_S0;
                o_mapped = 1'b1;
            end
            REGION_S1: begin
                o_sel    = SEL_S1;
                o_mapped = 1'b1;
            end
            REGION_S2: begin
                o_sel    = SEL_S2;
                o_mapped = 1'b1;
            end
            default: begin
                o_sel    = SEL_NONE;
                o_mapped = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master: host valid/ready requests are sequenced
// through SETUP/ACCESS with a bounded wait, answered by a one-cycle response.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              Pclk,
    input  logic              Preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              Pwrite,
    output logic              Penable,
    output logic [2:0]        Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e       r_state;
    logic [CNT_W-1:0] r_wait;
    logic [2:0]       w_sel;
    logic             w_mapped;
    logic             w_accept;
    logic             w_last_wait;

    apb_addr_decode u_decode (
        .i_region (req_addr[REGION_HI:REGION_LO]),
        .o_sel    (w_sel),
        .o_mapped (w_mapped)
    );

    assign w_accept    = req_valid && req_ready;
    // The current ACCESS cycle is the TIMEOUT-th one with no Pready so far
    assign w_last_wait = (r_wait == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            r_state   <= APB_IDLE;
            r_wait    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= RSP_OK;
            Pwrite    <= 1'b0;
            Penable   <= 1'b0;
            Pselx     <= SEL_NONE;
            Paddr     <= '0;
            Pwdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                APB_IDLE: begin
                    req_ready <= 1'b1;
                    Penable   <= 1'b0;
                    Pselx     <= SEL_NONE;
                    if (w_accept) begin
                        if (w_mapped) begin
                            r_state   <= APB_SETUP;
                            r_wait    <= '0;
                            req_ready <= 1'b0;
                            Pselx     <= w_sel;
                            Paddr     <= req_addr;
                            Pwrite    <= req_write;
                            Pwdata    <= req_wdata;
                        end else begin
                            // Unmapped: answer immediately, bus stays quiet
                            rsp_valid <= 1'b1;
                            rsp_err   <= RSP_ERR;
                            rsp_rdata <= '0;
                        end
                    end
                end

                APB_SETUP: begin
                    r_state <= APB_ACCESS;
                    Penable <= 1'b1;
                end

                APB_ACCESS: begin
                    if (Pready) begin
                        r_state   <= APB_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= RSP_OK;
                        rsp_rdata <= Pwrite ? '0 : Prdata;
                        Penable   <= 1'b0;
                        Pselx     <= SEL_NONE;
                    end else if (w_last_wait) begin
                        r_state   <= APB_IDLE;
                        r_wait    <= r_wait + CNT_W'(1);
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= RSP_ERR;
                        rsp_rdata <= '0;
                        Penable   <= 1'b0;
                        Pselx     <= SEL_NONE;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end

                default: begin
                    r_state   <= APB_IDLE;
                    req_ready <= 1'b1;
                    Penable   <= 1'b0;
                    Pselx     <= SEL_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: reset, zero-wait write, wait-state read,
// unmapped access, timeout edge cases, back-to-back reads, reset mid-ACCESS.
module tb_apb_master_ctrl;

    localparam int TIMEOUT = 16;

    logic        Pclk = 1'b0;
    logic        Preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        Pwrite;
    logic        Penable;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;

    logic [31:0] slv_rdata;
    logic        slv_echo;

    int checks = 0;
    int errors = 0;

    // Echo mode lets the slave answer with a value derived from Paddr
    assign Prdata = slv_echo ? (Paddr ^ 32'h5A5A_0000) : slv_rdata;

    always #5 Pclk = ~Pclk;

    apb_master_ctrl #(
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .Pclk      (Pclk),
        .Preset    (Preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Pwrite    (Pwrite),
        .Penable   (Penable),
        .Pselx     (Pselx),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Pclk);
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    logic [31:0] bb_addr [3];
    logic [31:0] bb_data [3];
    logic [2:0]  bb_sel  [3];

    initial begin
        Preset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        Pready    = 1'b1;
        slv_rdata = 32'hFFFF_FFFF;
        slv_echo  = 1'b0;
        bb_addr   = '{32'h0000_0100, 32'h4000_0200, 32'h8000_0300};
        bb_data   = '{32'h5A5A_0100, 32'h1A5A_0200, 32'hDA5A_0300};
        bb_sel    = '{3'b001, 3'b010, 3'b100};

        // Power-on reset
        step();
        step();
        chk("rst_pselx", 32'(Pselx), 32'h0);
        chk("rst_penable", 32'(Penable), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        Preset = 1'b0;
        step();
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        // Zero-wait write to slave 0
        drive_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        step();
        req_valid = 1'b0;
        chk("wr_setup_pselx", 32'(Pselx), 32'h1);
        chk("wr_setup_penable", 32'(Penable), 32'h0);
        chk("wr_setup_ready", 32'(req_ready), 32'h0);
        chk("wr_paddr", Paddr, 32'h0000_0010);
        chk("wr_pwrite", 32'(Pwrite), 32'h1);
        chk("wr_pwdata", Pwdata, 32'hDEAD_BEEF);
        step();
        chk("wr_access_penable", 32'(Penable), 32'h1);
        chk("wr_access_pselx", 32'(Pselx), 32'h1);
        chk("wr_access_rsp", 32'(rsp_valid), 32'h0);
        step();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wr_rsp_err", 32'(rsp_err), 32'h0);
        chk("wr_rsp_rdata", rsp_rdata, 32'h0);
        chk("wr_done_pselx", 32'(Pselx), 32'h0);
        chk("wr_done_penable", 32'(Penable), 32'h0);
        chk("wr_done_ready", 32'(req_ready), 32'h1);
        step();
        chk("wr_rsp_pulse", 32'(rsp_valid), 32'h0);

        // Read from slave 1 with three wait states
        Pready = 1'b0;
        drive_req(1'b0, 32'h4000_0004, 32'h0);
        step();
        req_valid = 1'b0;
        chk("rd_setup_pselx", 32'(Pselx), 32'h2);
        chk("rd_setup_penable", 32'(Penable), 32'h0);
        chk("rd_pwrite", 32'(Pwrite), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("rd_acc%0d_penable", i), 32'(Penable), 32'h1);
            chk($sformatf("rd_acc%0d_pselx", i), 32'(Pselx), 32'h2);
            chk($sformatf("rd_acc%0d_rsp", i), 32'(rsp_valid), 32'h0);
            if (i == 4) begin
                Pready    = 1'b1;
                slv_rdata = 32'h1234_5678;
            end
        end
        step();
        slv_rdata = 32'h0BAD_0BAD;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd_rsp_err", 32'(rsp_err), 32'h0);
        chk("rd_done_pselx", 32'(Pselx), 32'h0);

        // Unmapped region: immediate error, no bus activity
        step();
        drive_req(1'b0, 32'hC000_0000, 32'h0);
        step();
        req_valid = 1'b0;
        chk("um_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("um_rsp_err", 32'(rsp_err), 32'h1);
        chk("um_rsp_rdata", rsp_rdata, 32'h0);
        chk("um_pselx", 32'(Pselx), 32'h0);
        chk("um_ready", 32'(req_ready), 32'h1);
        step();
        chk("um_rsp_pulse", 32'(rsp_valid), 32'h0);
        chk("um_err_held", 32'(rsp_err), 32'h1);
        chk("um_pselx_quiet", 32'(Pselx), 32'h0);

        // Timeout: slave 2 never ready
        Pready    = 1'b0;
        slv_rdata = 32'hAAAA_5555;
        drive_req(1'b0, 32'h8000_0000, 32'h0);
        step();
        req_valid = 1'b0;
        chk("to_setup_pselx", 32'(Pselx), 32'h4);
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            chk($sformatf("to_acc%0d_penable", i), 32'(Penable), 32'h1);
            chk($sformatf("to_acc%0d_pselx", i), 32'(Pselx), 32'h4);
            chk($sformatf("to_acc%0d_rsp", i), 32'(rsp_valid), 32'h0);
        end
        step();
        chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to_rsp_err", 32'(rsp_err), 32'h1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        chk("to_pselx", 32'(Pselx), 32'h0);
        chk("to_penable", 32'(Penable), 32'h0);
        chk("to_ready", 32'(req_ready), 32'h1);

        // Pready on the TIMEOUT-th ACCESS cycle still succeeds
        step();
        drive_req(1'b0, 32'h8000_0008, 32'h0);
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            chk($sformatf("lt_acc%0d_rsp", i), 32'(rsp_valid), 32'h0);
            if (i == TIMEOUT) begin
                Pready    = 1'b1;
                slv_rdata = 32'hCAFE_F00D;
            end
        end
        step();
        chk("lt_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("lt_rsp_err", 32'(rsp_err), 32'h0);
        chk("lt_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);

        // Back-to-back reads with req_valid held high
        step();
        slv_echo = 1'b1;
        drive_req(1'b0, bb_addr[0], 32'h0);
        for (int r = 0; r < 3; r++) begin
            step();
            chk($sformatf("bb%0d_setup_pselx", r), 32'(Pselx), 32'(bb_sel[r]));
            chk($sformatf("bb%0d_setup_paddr", r), Paddr, bb_addr[r]);
            chk($sformatf("bb%0d_setup_ready", r), 32'(req_ready), 32'h0);
            chk($sformatf("bb%0d_setup_rsp", r), 32'(rsp_valid), 32'h0);
            if (r < 2) req_addr = bb_addr[r + 1];
            else       req_valid = 1'b0;
            step();
            chk($sformatf("bb%0d_access_ready", r), 32'(req_ready), 32'h0);
            chk($sformatf("bb%0d_access_penable", r), 32'(Penable), 32'h1);
            step();
            chk($sformatf("bb%0d_rsp_valid", r), 32'(rsp_valid), 32'h1);
            chk($sformatf("bb%0d_rsp_rdata", r), rsp_rdata, bb_data[r]);
            chk($sformatf("bb%0d_rsp_err", r), 32'(rsp_err), 32'h0);
            chk($sformatf("bb%0d_rsp_ready", r), 32'(req_ready), 32'h1);
        end
        step();
        chk("bb_no_dup_rsp", 32'(rsp_valid), 32'h0);
        chk("bb_no_dup_pselx", 32'(Pselx), 32'h0);
        slv_echo = 1'b0;

        // Reset held two cycles in the middle of ACCESS
        Pready = 1'b0;
        drive_req(1'b1, 32'h0000_0020, 32'h1111_2222);
        step();
        req_valid = 1'b0;
        step();
        chk("mr_access_penable", 32'(Penable), 32'h1);
        Preset = 1'b1;
        step();
        chk("mr_pselx", 32'(Pselx), 32'h0);
        chk("mr_penable", 32'(Penable), 32'h0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
        step();
        chk("mr_hold_pselx", 32'(Pselx), 32'h0);
        Preset = 1'b0;
        Pready = 1'b1;
        step();
        chk("mr_release_ready", 32'(req_ready), 32'h1);
        chk("mr_release_rsp", 32'(rsp_valid), 32'h0);
        step();
        chk("mr_no_late_rsp", 32'(rsp_valid), 32'h0);
        chk("mr_bus_idle", 32'(Pselx), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
